// File: rtl/ue14500_pc_seq.sv
// -----------------------------------------------------------------------------
// ue14500_pc_seq
//
// Program counter and fetch sequencer for the 1-bit ICU. It drives the program
// ROM address and follows the ICU's two-clock instruction cycle:
//   * phase 0 (fetch): the ICU latches ROM[ADDR].
//   * phase 1 (execute): the PC and the return stack are updated from the
//     ICU's JMP / RTN / FLF flags.
// The PC is therefore stable for the whole instruction.
//
// The return stack is a circular buffer. A push onto a full stack overwrites
// the oldest entry and sets the sticky OVF flag. A pop from an empty stack sets
// the sticky UNF flag and restarts the program at RESET_VEC.
//
// Parameters:
//   AW        PC / ROM address width
//   DEPTH     return-stack entries (power of two, >= 2)
//   RESET_VEC PC after reset and after a stack underflow
//
// Ports:
//   CLK      in   clock, shared with the ICU
//   RST      in   synchronous active-high reset (asserted together with ICU reset)
//   JMP      in   ICU jump flag, valid in phase 1
//   RTN      in   ICU return flag, valid in phase 1
//   FLF      in   ICU NOPF flag, valid in phase 1 (used only with halt support)
//   OPERAND  in   jump target, stable through phase 1
//   RUN      in   resume request (used only with halt support)
//   ADDR     out  ROM address (= PC)
//   PHASE    out  0 = fetch, 1 = execute
//   SP       out  stack occupancy, 0..DEPTH
//   OVF      out  sticky: push onto a full stack
//   UNF      out  sticky: pop from an empty stack
//   HALTED   out  halted state (only when UE14500_PC_HALT_EN is defined)
//
// Build option UE14500_PC_HALT_EN:
//   When defined, FLF in phase 1 halts the PC, so the ICU keeps re-fetching the
//   same NOPF. A RUN sampled in phase 1 while halted resumes at PC+1.
//   When undefined, FLF and RUN are ignored and the HALTED port is absent.
// -----------------------------------------------------------------------------
module ue14500_pc_seq #(
    parameter int            AW        = 8,
    parameter int            DEPTH     = 4,
    parameter logic [AW-1:0] RESET_VEC = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     JMP,
    input  logic                     RTN,
    input  logic                     FLF,
    input  logic [AW-1:0]            OPERAND,
    input  logic                     RUN,
    output logic [AW-1:0]            ADDR,
    output logic                     PHASE,
    output logic [$clog2(DEPTH):0]   SP,
    output logic                     OVF,
    output logic                     UNF
`ifdef UE14500_PC_HALT_EN
    ,
    output logic                     HALTED
`endif
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW:0]   SP_FULL = (PW+1)'(DEPTH);

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_t;

    phase_t          phase_q, phase_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [PW:0]     sp_q, sp_d;
    // top_q is the slot the next push writes. The newest entry is top_q-1.
    logic [PW-1:0]   top_q, top_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            push_en;

    logic [AW-1:0]   stack_mem [DEPTH];
    logic [AW-1:0]   top_rd_q;

`ifdef UE14500_PC_HALT_EN
    logic            halted_q, halted_d;
`else
    // FLF and RUN have no function without halt support.
    logic            unused_inputs;
    assign unused_inputs = FLF ^ RUN;
`endif

    // Next-state logic. All architectural updates happen in the execute phase.
    always_comb begin
        phase_d = (phase_q == PH_FETCH) ? PH_EXEC : PH_FETCH;
        pc_d    = pc_q;
        sp_d    = sp_q;
        top_d   = top_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
`ifdef UE14500_PC_HALT_EN
        halted_d = halted_q;
`endif
        if (phase_q == PH_EXEC) begin
`ifdef UE14500_PC_HALT_EN
            // While halted, the word at PC is the NOPF itself. Only RUN matters.
            if (halted_q) begin
                if (RUN) begin
                    halted_d = 1'b0;
                    pc_d     = pc_q + AW'(1);
                end
            end else
`endif
            if (JMP) begin
                // Push the JMP's own address. The post-RTN skip in the ICU
                // steps over it on return.
                push_en = 1'b1;
                top_d   = top_q + PW'(1);
                pc_d    = OPERAND;
                if (sp_q == SP_FULL) begin
                    ovf_d = 1'b1;          // oldest entry is overwritten
                end else begin
                    sp_d = sp_q + (PW+1)'(1);
                end
            end else if (RTN) begin
                if (sp_q != '0) begin
                    pc_d  = top_rd_q;
                    top_d = top_q - PW'(1);
                    sp_d  = sp_q - (PW+1)'(1);
                end else begin
                    unf_d = 1'b1;
                    pc_d  = RESET_VEC;
                end
            end
`ifdef UE14500_PC_HALT_EN
            else if (FLF) begin
                halted_d = 1'b1;           // PC holds on the NOPF
            end
`endif
            else begin
                pc_d = pc_q + AW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q <= PH_FETCH;
            pc_q    <= RESET_VEC;
            sp_q    <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
`ifdef UE14500_PC_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
`ifdef UE14500_PC_HALT_EN
            halted_q <= halted_d;
`endif
        end
    end

    // Return-stack RAM with a registered read port. The stack is written only
    // at execute edges. The newest entry can therefore be read at the fetch
    // edge, and the value is ready for a pop at the following execute edge.
    always_ff @(posedge CLK) begin
        if (push_en && !RST) begin
            stack_mem[top_q] <= pc_q;
        end
        if (phase_q == PH_FETCH) begin
            top_rd_q <= stack_mem[top_q - PW'(1)];
        end
    end

    assign ADDR  = pc_q;
    assign PHASE = (phase_q == PH_EXEC);
    assign SP    = sp_q;
    assign OVF   = ovf_q;
    assign UNF   = unf_q;
`ifdef UE14500_PC_HALT_EN
    assign HALTED = halted_q;
`endif

endmodule

// File: tb/tb_ue14500_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_ue14500_pc_seq
//
// Self-checking bench for ue14500_pc_seq (AW=8, DEPTH=4, RESET_VEC=0).
// A table of per-clock vectors covers reset, sequential fetch and a single
// call/return. Hand-written sequences cover the following cases:
//   * nested calls with overflow
//   * underflow
//   * reset during a JMP instruction
//   * FLF halt/resume
//   * PC wrap-around
// -----------------------------------------------------------------------------
module tb_ue14500_pc_seq;

    logic       clk;
    logic       rst;
    logic       jmp;
    logic       rtn;
    logic       flf;
    logic [7:0] operand;
    logic       run;
    logic [7:0] addr;
    logic       phase;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;
`ifdef UE14500_PC_HALT_EN
    logic       halted;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ue14500_pc_seq #(
        .AW        (8),
        .DEPTH     (4),
        .RESET_VEC (8'h00)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .JMP     (jmp),
        .RTN     (rtn),
        .FLF     (flf),
        .OPERAND (operand),
        .RUN     (run),
        .ADDR    (addr),
        .PHASE   (phase),
        .SP      (sp),
        .OVF     (ovf),
        .UNF     (unf)
`ifdef UE14500_PC_HALT_EN
        ,
        .HALTED  (halted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       jmp;
        logic       rtn;
        logic [7:0] op;
        logic [7:0] addr;
        logic       phase;
        logic [2:0] sp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic j, input logic t,
                                input logic [7:0] op, input logic [7:0] a,
                                input logic ph, input logic [2:0] s);
        vec_t v;
        v.rst = r; v.jmp = j; v.rtn = t; v.op = op;
        v.addr = a; v.phase = ph; v.sp = s;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full instruction starting in phase 0. Flags are driven only in phase 1.
    task automatic instr(input logic j, input logic t, input logic f, input logic [7:0] op);
        tick();
        jmp = j; rtn = t; flf = f; operand = op;
        tick();
        jmp = 1'b0; rtn = 1'b0; flf = 1'b0; operand = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; jmp = 1'b0; rtn = 1'b0; flf = 1'b0; run = 1'b0; operand = 8'h00;

        // ---- table: reset, 10 plain clocks, then a call/return ----
        add(1, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 0, 8'h00, 8'h00, 1, 0);
        add(0, 0, 0, 8'h00, 8'h01, 0, 0);
        add(0, 0, 0, 8'h00, 8'h01, 1, 0);
        add(0, 0, 0, 8'h00, 8'h02, 0, 0);
        add(0, 0, 0, 8'h00, 8'h02, 1, 0);
        add(0, 0, 0, 8'h00, 8'h03, 0, 0);
        add(0, 0, 0, 8'h00, 8'h03, 1, 0);
        add(0, 0, 0, 8'h00, 8'h04, 0, 0);
        add(0, 0, 0, 8'h00, 8'h04, 1, 0);
        add(0, 0, 0, 8'h00, 8'h05, 0, 0);
        add(0, 0, 0, 8'h00, 8'h05, 1, 0);   // fetch JMP at 0x05
        add(0, 1, 0, 8'h40, 8'h40, 0, 1);   // execute JMP 0x40
        add(0, 0, 0, 8'h00, 8'h40, 1, 1);
        add(0, 0, 0, 8'h00, 8'h41, 0, 1);
        add(0, 0, 0, 8'h00, 8'h41, 1, 1);
        add(0, 0, 0, 8'h00, 8'h42, 0, 1);
        add(0, 0, 0, 8'h00, 8'h42, 1, 1);   // fetch RTN at 0x42
        add(0, 0, 1, 8'h00, 8'h05, 0, 0);   // back to the call site
        add(0, 0, 0, 8'h00, 8'h05, 1, 0);
        add(0, 0, 0, 8'h00, 8'h06, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; jmp = vecs[i].jmp; rtn = vecs[i].rtn; operand = vecs[i].op;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_addr", i),  addr,  vecs[i].addr);
            check($sformatf("vec%0d_phase", i), phase, vecs[i].phase);
            check($sformatf("vec%0d_sp", i),    sp,    vecs[i].sp);
            if (i == 0) begin
                check("reset_ovf", ovf, 0);
                check("reset_unf", unf, 0);
            end
        end
        rst = 1'b0; jmp = 1'b0; rtn = 1'b0; operand = 8'h00;

        // ---- five nested calls from 0x10..0x14, overflow on the fifth ----
        do_reset();
        repeat (16) instr(0, 0, 0, 8'h00);
        check("nest_start_addr", addr, 8'h10);
        for (int i = 0; i < 5; i++) begin
            instr(1, 0, 0, 8'(8'h11 + i));
            check($sformatf("nest%0d_addr", i), addr, 8'h11 + i);
            check($sformatf("nest%0d_sp", i),   sp,   (i < 4) ? i + 1 : 4);
            check($sformatf("nest%0d_ovf", i),  ovf,  (i == 4) ? 1 : 0);
        end
        for (int k = 0; k < 4; k++) begin
            instr(0, 1, 0, 8'h00);
            check($sformatf("ret%0d_addr", k), addr, 8'h14 - k);
            check($sformatf("ret%0d_sp", k),   sp,   3 - k);
        end

        // ---- pop from empty stack ----
        instr(0, 1, 0, 8'h00);
        check("unf_flag", unf, 1);
        check("unf_addr", addr, 8'h00);
        check("unf_sp",   sp,   0);
        check("unf_ovf_sticky", ovf, 1);

        // ---- reset during a JMP execute cycle ----
        tick();
        jmp = 1'b1; operand = 8'h33; rst = 1'b1;
        tick();
        jmp = 1'b0; operand = 8'h00; rst = 1'b0;
        check("rstjmp_addr",  addr,  8'h00);
        check("rstjmp_sp",    sp,    0);
        check("rstjmp_phase", phase, 0);
        check("rstjmp_ovf",   ovf,   0);
        check("rstjmp_unf",   unf,   0);
        tick();
        check("rstjmp_next_phase", phase, 1);
        check("rstjmp_next_addr",  addr,  8'h00);

        // ---- FLF at 0x20 ----
        do_reset();
        repeat (32) instr(0, 0, 0, 8'h00);
        check("flf_start_addr", addr, 8'h20);
        instr(0, 0, 1, 8'h00);
`ifdef UE14500_PC_HALT_EN
        check("halt_flag", halted, 1);
        check("halt_addr", addr, 8'h20);
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("halt_hold%0d_addr", c), addr, 8'h20);
            check($sformatf("halt_hold%0d_flag", c), halted, 1);
        end
        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
        check("resume_flag", halted, 0);
        check("resume_addr", addr, 8'h21);
`else
        check("flf_ignored_addr", addr, 8'h21);
`endif

        // ---- PC wrap-around 0xFF -> 0x00 ----
        instr(1, 0, 0, 8'hFF);
        check("wrap_jmp_addr", addr, 8'hFF);
        instr(0, 0, 0, 8'h00);
        check("wrap_addr", addr, 8'h00);
        check("wrap_sp",   sp,   1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
